tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each slot word.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  high when in_data carries one slot word this cycle.
REQ-005 in_data  input  WIDTH  serial slot word from the 4:1 time-division stream.
REQ-006 in_sof  input  1  start-of-frame; qualified by in_valid; marks slot 0.
REQ-007 a, b, c, d  output  WIDTH each  recovered slot 0/1/2/3 words, registered.
REQ-008 out_valid  output  1  one-cycle pulse; a..d just updated with a complete frame.
REQ-009 s1, s0  output  1 each  expected slot index of the next accepted beat (s1 = MSB).
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 FSM states: HUNT and LOCKED.
REQ-013 Slot counter: 2 bits; wraps 3 -> 0; advances only on an accepted beat (in_valid = 1 while LOCKED, or the locking beat).
REQ-014 HUNT: beats with in_sof = 0 are discarded; the counter stays 0.
REQ-015 HUNT, in_valid & in_sof: store the word in slot-0 shadow; counter -> 1; next state LOCKED; no sync_err.
REQ-016 LOCKED, in_valid, counter = k, in_sof consistent with k: store the word in shadow slot k; counter -> k+1 mod 4.
REQ-017 Consistency rule: in_sof = 1 exactly when k = 0.
REQ-018 LOCKED, in_valid & in_sof with k != 0 (early SOF):
- pulse sync_err;
- discard the partial frame;
- store the word as slot 0; counter -> 1;
- stay LOCKED.
REQ-019 LOCKED, in_valid & !in_sof with k = 0 (missing SOF): pulse sync_err; discard the word; counter stays 0; next state HUNT.
REQ-020 Beat accepted at k = 3, on the same edge:
- a..d load shadow slots 0..2 plus the current word as d;
- out_valid = 1 during the following cycle only.
REQ-021 Latency: a..d and out_valid are visible in the cycle after the slot-3 beat.
REQ-022 a..d hold their values between completed frames; partial or discarded frames never alter a..d.
REQ-023 in_valid = 0: no state, counter or shadow change; in_sof and in_data are ignored.
REQ-024 {s1,s0} equals the counter value in both states; it is 0 in HUNT.
REQ-025 locked is registered; it reflects the FSM state.
REQ-026 sync_err and out_valid never assert in the same cycle.
REQ-027 Back-to-back frames at one beat per cycle give one out_valid every 4 cycles with no bubble.

Reset
REQ-028 rst_n low forces, immediately and independent of clk:
- state HUNT, counter 0;
- shadows and a..d all zero;
- out_valid, sync_err and locked all 0.
REQ-029 Reset assertion mid-frame discards the partial frame.
REQ-030 After rst_n deasserts, the first beat is processed per REQ-014/015.

Structure
REQ-031 A shared package tdm_pkg holds:
- SLOTS = 4;
- slot index typedef (2 bits);
- FSM state enum {HUNT, LOCKED}.
REQ-032 The slot counter with its wrap and clear controls is one sub-module, tdm_slot_cnt, instantiated once.
REQ-033 All remaining logic lives in tdm_demux4; no latches; outputs are driven directly from flops.

Verification
REQ-034 Reset, then in_valid every cycle, WIDTH = 4, frames {SOF:1, 2, 3, 4} then {SOF:5, 6, 7, 8} -> locked = 1 after the first beat; a..d = 1,2,3,4 with out_valid one cycle after the 4th beat; then 5,6,7,8 four cycles later; sync_err never asserts.
REQ-035 Stall: beats 1, 2, gap of 3 idle cycles, 3, 4 -> {s1,s0} holds 2 during the gap; a..d = 1,2,3,4 one cycle after beat 4; single out_valid.
REQ-036 Early SOF: SOF:1, 2, then SOF:9, A, B, C -> sync_err pulse on the cycle after the SOF:9 beat; a..d = 9,A,B,C; a..d are never 1,2,x,x.
REQ-037 Missing SOF: full frame 1..4, then a non-SOF beat 5 -> sync_err pulse; locked = 0; a..d stay 1,2,3,4; a subsequent SOF frame relocks normally.
REQ-038 Beats with in_sof = 0 before any SOF in HUNT -> discarded; locked = 0; no sync_err.
REQ-039 rst_n pulsed low after beat 3 of a frame -> outputs zero asynchronously; state HUNT; the following full SOF frame is recovered correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot count, slot index type and framing FSM states for the TDM demux
package tdm_pkg;
    localparam int SLOTS = 4;
    typedef logic [1:0] slot_t;
    localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial slot stream in, recovered four-slot frame and framing status out
interface tdm_demux4_if #(parameter int WIDTH = 1);
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             s1;
    logic             s0;
    logic             locked;
    logic             sync_err;
    modport master (
        output in_valid, in_sof, in_data,
        input  a, b, c, d, out_valid, s1, s0, locked, sync_err
    );
    modport slave (
        input  in_valid, in_sof, in_data,
        output a, b, c, d, out_valid, s1, s0, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_cnt.sv
// tdm_slot_cnt: 2-bit slot counter; clr restarts from slot 0, inc advances with 3 -> 0 wrap
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  clr,
    output slot_t cnt
);
    slot_t base;
    assign base = clr ? '0 : cnt;
    // clr with inc lands on slot 1: the restarting beat itself is slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (inc || clr) cnt <= inc ? slot_t'(base + 2'd1) : base;
    end
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers four slot words from a 4:1 TDM stream with SOF-based frame lock
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);
    state_t           state;
    state_t           state_nxt;
    slot_t            cnt;
    logic             inc;
    logic             clr;
    logic             err;
    logic             wr_first;
    logic             wr_mid;
    logic             done;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             sync_err;

    tdm_slot_cnt u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .clr   (clr),
        .cnt   (cnt)
    );

    // framing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else state <= state_nxt;
    end

    // classify each valid beat: lock, in-order slot, early SOF or missing SOF
    always_comb begin
        state_nxt = state;
        inc       = 1'b0;
        clr       = 1'b0;
        err       = 1'b0;
        wr_first  = 1'b0;
        wr_mid    = 1'b0;
        done      = 1'b0;
        if (bus.in_valid) begin
            if (state == HUNT) begin
                if (bus.in_sof) begin
                    state_nxt = LOCKED;
                    inc       = 1'b1;
                    wr_first  = 1'b1;
                end
            end else if (bus.in_sof) begin
                inc      = 1'b1;
                clr      = cnt != '0;
                err      = cnt != '0;
                wr_first = 1'b1;
            end else if (cnt == '0) begin
                err       = 1'b1;
                state_nxt = HUNT;
            end else begin
                inc    = 1'b1;
                wr_mid = 1'b1;
                done   = cnt == LAST_SLOT;
            end
        end
    end

    // shadow slots 0..2; slot 3 goes straight to d when the frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0 <= '0;
            sh1 <= '0;
            sh2 <= '0;
        end else begin
            if (wr_first) sh0 <= bus.in_data;
            if (wr_mid && cnt == 2'd1) sh1 <= bus.in_data;
            if (wr_mid && cnt == 2'd2) sh2 <= bus.in_data;
        end
    end

    // publish a completed frame and the one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= done;
            sync_err  <= err;
            if (done) begin
                a <= sh0;
                b <= sh1;
                c <= sh2;
                d <= bus.in_data;
            end
        end
    end

    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.c         = c;
    assign bus.d         = d;
    assign bus.out_valid = out_valid;
    assign bus.sync_err  = sync_err;
    assign bus.locked    = state == LOCKED;
    assign bus.s1        = cnt[1];
    assign bus.s0        = cnt[0];
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed framing scenarios with a scoreboard of expected frames
module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   err_seen = 0;
    logic [15:0] exp_q[$];

    tdm_demux4_if #(.WIDTH(4)) bus ();

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame();
        return {bus.a, bus.b, bus.c, bus.d};
    endfunction

    task automatic step(input logic v, input logic sof, input logic [3:0] data);
        logic [15:0] e;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = data;
        @(posedge clk);
        @(negedge clk);
        if (bus.sync_err) err_seen++;
        chk("ov_err_excl", 16'(bus.out_valid & bus.sync_err), 16'h0);
        if (bus.out_valid) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", 16'h1, 16'h0);
            else begin
                e = exp_q.pop_front();
                chk("frame", frame(), e);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_abcd"}, frame(), 16'h0);
        chk({tag, "_flags"}, 16'({bus.out_valid, bus.sync_err, bus.locked, bus.s1, bus.s0}), 16'h0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 4'h0;
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        // back-to-back frames
        step(1, 1, 4'h1);
        chk("lock_first_beat", 16'(bus.locked), 16'h1);
        chk("slot_after_sof", 16'({bus.s1, bus.s0}), 16'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        exp_q.push_back(16'h1234);
        step(1, 0, 4'h4);
        chk("ov_frame1", 16'(bus.out_valid), 16'h1);
        step(1, 1, 4'h5);
        chk("ov_one_cycle", 16'(bus.out_valid), 16'h0);
        step(1, 0, 4'h6);
        step(1, 0, 4'h7);
        exp_q.push_back(16'h5678);
        step(1, 0, 4'h8);
        chk("ov_frame2", 16'(bus.out_valid), 16'h1);
        chk("no_sync_err", 16'(err_seen), 16'h0);
        // stall mid-frame
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'hF);
            chk("stall_slot", 16'({bus.s1, bus.s0}), 16'h2);
            chk("stall_abcd", frame(), 16'h5678);
        end
        step(1, 0, 4'h3);
        exp_q.push_back(16'h1234);
        step(1, 0, 4'h4);
        chk("ov_stall", 16'(bus.out_valid), 16'h1);
        // early SOF
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 1, 4'h9);
        chk("early_sof_err", 16'(bus.sync_err), 16'h1);
        chk("early_sof_locked", 16'(bus.locked), 16'h1);
        chk("early_sof_slot", 16'({bus.s1, bus.s0}), 16'h1);
        step(1, 0, 4'hA);
        chk("early_err_pulse", 16'(bus.sync_err), 16'h0);
        step(1, 0, 4'hB);
        exp_q.push_back(16'h9ABC);
        step(1, 0, 4'hC);
        chk("ov_early", 16'(bus.out_valid), 16'h1);
        // missing SOF
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        exp_q.push_back(16'h1234);
        step(1, 0, 4'h4);
        step(1, 0, 4'h5);
        chk("miss_sof_err", 16'(bus.sync_err), 16'h1);
        chk("miss_sof_unlock", 16'(bus.locked), 16'h0);
        chk("miss_sof_slot", 16'({bus.s1, bus.s0}), 16'h0);
        chk("miss_sof_hold", frame(), 16'h1234);
        step(1, 1, 4'h5);
        chk("relock", 16'(bus.locked), 16'h1);
        step(1, 0, 4'h6);
        step(1, 0, 4'h7);
        exp_q.push_back(16'h5678);
        step(1, 0, 4'h8);
        chk("ov_relock", 16'(bus.out_valid), 16'h1);
        // non-SOF beats in HUNT after reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        err_seen = 0;
        step(1, 0, 4'h7);
        step(1, 0, 4'h3);
        chk("hunt_unlocked", 16'(bus.locked), 16'h0);
        chk("hunt_slot", 16'({bus.s1, bus.s0}), 16'h0);
        chk("hunt_no_err", 16'(err_seen), 16'h0);
        step(1, 1, 4'hD);
        step(1, 0, 4'hE);
        step(1, 0, 4'hF);
        exp_q.push_back(16'hDEF0);
        step(1, 0, 4'h0);
        chk("ov_hunt", 16'(bus.out_valid), 16'h1);
        // asynchronous reset mid-frame
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 4'h4);
        chk("post_reset_lock", 16'(bus.locked), 16'h1);
        step(1, 0, 4'h5);
        step(1, 0, 4'h6);
        exp_q.push_back(16'h4567);
        step(1, 0, 4'h7);
        chk("ov_post_reset", 16'(bus.out_valid), 16'h1);
        step(0, 0, 4'h0);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
